log_histogram: RTL and testbench
================================

# log_histogram

Downstream consumer of the 8-bit floor-log2 stage. It accepts one log2 result per handshake and keeps saturating per-bin occurrence counters: eight magnitude bins (log2 = 0..7) and one bin for zero-valued inputs. On request it streams out all nine counters through a valid/ready port, clearing each counter as it is read. It then resumes counting.

## Interface
- CNT_W, 16, width of each bin counter; legal range 4..32
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  in_log/in_zero hold a valid sample
- in_ready  output  1  block accepts a sample this cycle
- in_log  input  3  floor(log2) of the sample, from the log stage
- in_zero  input  1  sample value was 0; upstream derives it as number == 0
- dump_req  input  1  single-cycle pulse requesting a counter readout
- busy  output  1  high while a dump is in progress
- out_valid  output  1  out_bin/out_count/out_last are valid
- out_ready  input  1  downstream accepts the readout word
- out_bin  output  4  bin index 0..8; 8 is the zero bin
- out_count  output  CNT_W  counter value of out_bin
- out_last  output  1  marks the final word of a dump (bin 8)
- sat_flag  output  1  sticky: some counter saturated since the last completed dump

## Operation
- State machine has two states: COUNT and DUMP. Reset state is COUNT.
- Reset values:
  - All nine counters are 0.
  - sat_flag = 0, busy = 0, out_valid = 0, out_bin = 0, out_last = 0.
  - in_ready = 1 once rst_n is deasserted.
- COUNT state:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready, the selected bin increments by 1. The selected bin is 8 when in_zero = 1 (in_log is ignored), otherwise in_log.
- Saturation:
  - A counter at 2^CNT_W-1 stays at that value.
  - An increment attempted on a saturated counter sets sat_flag.
  - Reaching the maximum value by itself does not set sat_flag.
- dump_req sampled high in COUNT: the next state is DUMP with read index 0.
  - A sample accepted in that same cycle is still counted.
- DUMP state:
  - in_ready = 0, busy = 1, out_valid = 1.
  - out_bin = read index; out_count = the current value of that counter; out_last = (index == 8).
  - On out_valid && out_ready, that counter clears to 0 and the index increments.
  - The handshake on index 8 returns the block to COUNT and clears sat_flag.
- dump_req while in DUMP is ignored; it is neither queued nor restarting the dump.
- While out_ready = 0, all out_* signals hold stable.
- Asserting rst_n low at any point, including mid-dump, returns the block to the reset values immediately. The partially dumped data is lost.

## Timing
- Input counting: a sample accepted at edge N is visible in its counter after edge N.
- Throughput is 1 sample per cycle in COUNT.
- dump_req high at edge N:
  - in_ready falls and out_valid rises in the cycle after edge N.
  - First word: bin 0.
- Each readout word takes at least 1 cycle. A full dump with out_ready held at 1 takes exactly 9 cycles.
- in_ready returns high in the cycle after the bin-8 handshake.
- All outputs are driven from registers or from a mux of registers; there is no combinational path from any input to any output.

## Test plan
- Basic fill and dump:
  - Stimulus: after reset, send samples with in_log = 0,3,3,7 (in_zero = 0), then one sample with in_zero = 1; then pulse dump_req with out_ready = 1.
  - Required: 9 words, bins 0..8, counts 1,0,0,2,0,0,0,1,1; out_last only on bin 8; busy high for 9 cycles.
- Read-clear:
  - Stimulus: immediately dump a second time with no input in between.
  - Required: all nine counts are 0 and sat_flag = 0.
- Saturation (CNT_W = 4):
  - Stimulus: send 17 samples to bin 5, then dump.
  - Required: bin 5 reads 15; sat_flag is 1 before the dump and 0 after the bin-8 handshake.
- Backpressure and dump-time input:
  - Stimulus: during a dump, hold out_ready = 0 for 5 cycles at bin 2; drive in_valid = 1 throughout the dump.
  - Required: out_bin/out_count hold stable while stalled; in_ready = 0 during the dump; no counter changes from input during the dump.
- Simultaneous events:
  - Stimulus: assert dump_req in the same cycle as an accepted sample with in_log = 4; in a separate test, pulse dump_req again mid-dump.
  - Required: bin 4 reads 1 in the dump that follows; the mid-dump dump_req has no effect and only 9 words are produced.
- Reset mid-dump:
  - Stimulus: drop rst_n while bin 3 is being presented.
  - Required: out_valid = 0 and busy = 0 immediately; after release, a dump reads all zeros.

Source files
------------

// File: rtl/log_histogram.sv
// Saturating nine-bin histogram of floor-log2 samples (eight magnitude bins plus a zero bin),
// with a read-and-clear dump of all counters through a valid/ready stream.
module log_histogram #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_log,
  input  logic             in_zero,
  input  logic             dump_req,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_bin,
  output logic [CNT_W-1:0] out_count,
  output logic             out_last,
  output logic             sat_flag
);

  typedef enum logic {
    ST_COUNT,
    ST_DUMP
  } state_e;

  localparam int unsigned     NBINS    = 9;
  localparam logic [3:0]      LAST_BIN = 4'd8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] cnt_q [NBINS];
  logic [CNT_W-1:0] cnt_d [NBINS];

  logic [3:0]       sel_bin;
  logic             accept;
  logic             rd_fire;
  logic [CNT_W-1:0] rd_count;

  // The zero flag overrides in_log, which is meaningless for a zero sample.
  always_comb begin
    sel_bin = in_zero ? LAST_BIN : {1'b0, in_log};
    accept  = (state_q == ST_COUNT) && in_valid;
    rd_fire = (state_q == ST_DUMP) && out_ready;
  end

  always_comb begin
    rd_count = '0;
    for (int unsigned b = 0; b < NBINS; b++) begin
      if (idx_q == b[3:0]) rd_count = cnt_q[b];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sat_d   = sat_q;
    for (int unsigned b = 0; b < NBINS; b++) begin
      cnt_d[b] = cnt_q[b];
    end

    case (state_q)
      ST_COUNT: begin
        for (int unsigned b = 0; b < NBINS; b++) begin
          if (accept && (sel_bin == b[3:0])) begin
            if (cnt_q[b] == CNT_MAX) sat_d = 1'b1;
            else                     cnt_d[b] = cnt_q[b] + CNT_ONE;
          end
        end
        if (dump_req) begin
          state_d = ST_DUMP;
          idx_d   = '0;
        end
      end
      ST_DUMP: begin
        if (rd_fire) begin
          for (int unsigned b = 0; b < NBINS; b++) begin
            if (idx_q == b[3:0]) cnt_d[b] = '0;
          end
          if (idx_q == LAST_BIN) begin
            state_d = ST_COUNT;
            idx_d   = '0;
            sat_d   = 1'b0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_COUNT;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COUNT;
      idx_q   <= '0;
      sat_q   <= 1'b0;
      for (int unsigned b = 0; b < NBINS; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
      for (int unsigned b = 0; b < NBINS; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  // Every output is decoded from registered state only.
  always_comb begin
    in_ready  = (state_q == ST_COUNT);
    busy      = (state_q == ST_DUMP);
    out_valid = (state_q == ST_DUMP);
    out_bin   = idx_q;
    out_count = rd_count;
    out_last  = (state_q == ST_DUMP) && (idx_q == LAST_BIN);
    sat_flag  = sat_q;
  end

endmodule

// File: tb/tb_log_histogram.sv
// Bench for log_histogram with 4-bit counters: a bin model feeds a scoreboard of expected
// dump words, checked word-by-word as the DUT streams them out.
module tb_log_histogram;

  localparam int unsigned CW   = 4;
  localparam int          CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_log = '0;
  logic          in_zero = 1'b0;
  logic          dump_req = 1'b0;
  logic          busy;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    out_bin;
  logic [CW-1:0] out_count;
  logic          out_last;
  logic          sat_flag;

  log_histogram #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_log    (in_log),
    .in_zero   (in_zero),
    .dump_req  (dump_req),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_count (out_count),
    .out_last  (out_last),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int cnt;
    bit last;
  } exp_t;

  typedef struct {
    bit       zero;
    bit [2:0] lg;
  } vec_t;

  exp_t sb[$];
  int   mdl [9];
  bit   mdl_sat;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_inc(input bit z, input bit [2:0] lg);
    int b;
    b = z ? 8 : int'(lg);
    if (mdl[b] == CMAX) mdl_sat = 1'b1;
    else                mdl[b]++;
  endtask

  task automatic send(input bit z, input bit [2:0] lg);
    in_valid = 1'b1;
    in_zero  = z;
    in_log   = lg;
    chk("in_ready_count", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    model_inc(z, lg);
  endtask

  task automatic push_model();
    for (int b = 0; b < 9; b++) begin
      sb.push_back('{b, mdl[b], b == 8});
      mdl[b] = 0;
    end
  endtask

  // Runs one dump against the scoreboard; optional stall, input traffic, and stray dump_req.
  task automatic dump(input int stall_bin, input int stall_n, input bit drive_in,
                      input int req_bin, input bit with_sample, input bit [2:0] slog);
    exp_t e;
    int   busy_cyc;
    busy_cyc  = 0;
    out_ready = 1'b1;
    dump_req  = 1'b1;
    in_valid  = with_sample;
    in_zero   = 1'b0;
    in_log    = slog;
    tick();
    dump_req = 1'b0;
    in_valid = 1'b0;
    chk("busy_after_req", int'(busy), 1);
    chk("in_ready_after_req", int'(in_ready), 0);
    for (int w = 0; w < 9; w++) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 0, 1);
        break;
      end
      e = sb.pop_front();
      if (drive_in) begin
        in_valid = 1'b1;
        in_zero  = 1'($urandom_range(0, 1));
        in_log   = 3'($urandom_range(0, 7));
      end
      if (w == stall_bin) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_bin", int'(out_bin), e.bin);
          chk("stall_count", int'(out_count), e.cnt);
          chk("stall_in_ready", int'(in_ready), 0);
          if (busy) busy_cyc++;
          tick();
        end
        out_ready = 1'b1;
      end
      chk("word_valid", int'(out_valid), 1);
      chk("word_bin", int'(out_bin), e.bin);
      chk("word_count", int'(out_count), e.cnt);
      chk("word_last", int'(out_last), int'(e.last));
      chk("dump_in_ready", int'(in_ready), 0);
      if (w == req_bin) dump_req = 1'b1;
      if (busy) busy_cyc++;
      tick();
      dump_req = 1'b0;
    end
    in_valid = 1'b0;
    mdl_sat  = 1'b0;
    chk("busy_cycles", busy_cyc, 9 + stall_n);
    chk("busy_end", int'(busy), 0);
    chk("out_valid_end", int'(out_valid), 0);
    chk("in_ready_end", int'(in_ready), 1);
    chk("sat_after_dump", int'(sat_flag), 0);
  endtask

  initial begin
    vec_t samples1 [5];
    int   exp1 [9];
    samples1 = '{'{1'b0, 3'd0}, '{1'b0, 3'd3}, '{1'b0, 3'd3}, '{1'b0, 3'd7}, '{1'b1, 3'd5}};
    exp1     = '{1, 0, 0, 2, 0, 0, 0, 1, 1};
    for (int b = 0; b < 9; b++) mdl[b] = 0;
    mdl_sat = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_bin", int'(out_bin), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_sat", int'(sat_flag), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Basic fill and dump, expected counts from the table.
    for (int i = 0; i < 5; i++) send(samples1[i].zero, samples1[i].lg);
    for (int b = 0; b < 9; b++) begin
      sb.push_back('{b, exp1[b], b == 8});
      mdl[b] = 0;
    end
    dump(-1, 0, 1'b0, -1, 1'b0, 3'd0);

    // Read-clear.
    push_model();
    dump(-1, 0, 1'b0, -1, 1'b0, 3'd0);

    // Saturation at 15 with 4-bit counters.
    for (int i = 0; i < 17; i++) begin
      send(1'b0, 3'd5);
      if (i == 14) chk("sat_at_max", int'(sat_flag), 0);
    end
    chk("sat_set", int'(sat_flag), int'(mdl_sat));
    chk("sat_bin5_model", mdl[5], 15);
    push_model();
    dump(-1, 0, 1'b0, -1, 1'b0, 3'd0);

    // Backpressure at bin 2 with input traffic throughout the dump.
    for (int i = 0; i < 3; i++) send(1'b0, 3'd2);
    send(1'b1, 3'd0);
    send(1'b1, 3'd6);
    send(1'b0, 3'd1);
    push_model();
    dump(2, 5, 1'b1, -1, 1'b0, 3'd0);
    push_model();
    dump(-1, 0, 1'b0, -1, 1'b0, 3'd0);

    // dump_req together with an accepted sample.
    send(1'b0, 3'd6);
    model_inc(1'b0, 3'd4);
    push_model();
    dump(-1, 0, 1'b0, -1, 1'b1, 3'd4);

    // Stray dump_req mid-dump.
    send(1'b0, 3'd7);
    push_model();
    dump(-1, 0, 1'b0, 4, 1'b0, 3'd0);
    for (int i = 0; i < 2; i++) begin
      chk("no_extra_dump", int'(out_valid), 0);
      tick();
    end

    // Reset while bin 3 is presented.
    send(1'b0, 3'd3);
    send(1'b0, 3'd3);
    out_ready = 1'b1;
    dump_req  = 1'b1;
    tick();
    dump_req = 1'b0;
    repeat (3) tick();
    chk("pre_rst_bin", int'(out_bin), 3);
    chk("pre_rst_count", int'(out_count), 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    tick();
    rst_n = 1'b1;
    for (int b = 0; b < 9; b++) mdl[b] = 0;
    mdl_sat = 1'b0;
    tick();
    push_model();
    dump(-1, 0, 1'b0, -1, 1'b0, 3'd0);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
